// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and serve constants for the brick-breaker game
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Serve position and launch vector loaded by the top level on serve_load
  localparam int         SERVE_X   = 320;
  localparam int         SERVE_Y   = 240;
  localparam int         SERVE_VX  = 8;
  localparam int         SERVE_VY  = 6;
  localparam logic [1:0] SERVE_DIR = 2'b10;

  // Paddle line; the ball counts as missed a few pixels below it
  localparam int         PADDLE_Y  = 467;

endpackage

// File: rtl/game_state_ctrl_if.sv
// rtl/game_state_ctrl_if.sv - ball-controller to game-state-controller signal bundle
interface game_state_ctrl_if;

  logic        key_start;
  logic        collision_trig;
  logic [9:0]  ball_y;
  logic        bricks_empty;
  logic        run;
  logic        serve_load;
  logic        game_start;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        game_over;
  logic        win;

  // Upstream side: ball controller / keyboard, consumes the control outputs
  modport master (
    output key_start, collision_trig, ball_y, bricks_empty,
    input  run, serve_load, game_start, state, lives, score, game_over, win
  );

  // Controller side
  modport slave (
    input  key_start, collision_trig, ball_y, bricks_empty,
    output run, serve_load, game_start, state, lives, score, game_over, win
  );

endinterface

// File: rtl/game_state_ctrl_bcd_score4.sv
// rtl/game_state_ctrl_bcd_score4.sv - 4-digit BCD score accumulator with saturation at 9999
module bcd_score4 (
  input  logic        clk_22,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic [3:0]  amount,
  output logic [15:0] score
);

  logic [15:0] sum;
  logic        carry;
  logic [4:0]  digit;

  // Ripple the amount through the four decimal digits; a carry out of digit 3 means overflow
  always_comb begin
    sum   = score;
    carry = 1'b0;
    digit = 5'd0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, score[4*i +: 4]} + {1'b0, (i == 0) ? amount : 4'd0} + {4'd0, carry};
      if (digit > 5'd9) begin
        sum[4*i +: 4] = 4'(digit - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[4*i +: 4] = digit[3:0];
        carry         = 1'b0;
      end
    end
  end

  // Clear wins over increment; overflow pins the display at 9999 instead of wrapping
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      score <= 16'h0000;
    end else if (clr) begin
      score <= 16'h0000;
    end else if (inc) begin
      score <= carry ? 16'h9999 : sum;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - round, lives and score controller for the brick-breaker game
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MISS_Y       = PADDLE_Y + 3,
  parameter int SERVE_DELAY  = 24,
  parameter int BRICK_POINTS = 1,
  parameter int END_HOLD     = 48
) (
  input logic               clk_22,
  input logic               rst,
  game_state_ctrl_if.slave  bus
);

  localparam int SW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int EW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

  state_t      st;
  logic        key_q;
  logic [SW-1:0] serve_cnt;
  logic [EW-1:0] end_cnt;
  logic [1:0]  lives;
  logic        run;
  logic        serve_load;
  logic        game_start;
  logic        game_over;
  logic        win;

  logic        start_edge;
  logic        end_done;
  logic        miss;
  logic        accept_start;
  logic        score_inc;

  assign start_edge   = bus.key_start & ~key_q;
  assign end_done     = (end_cnt == EW'(END_HOLD - 1));
  assign miss         = (bus.ball_y >= 10'(MISS_Y));
  // A new game may begin from idle, or from an end screen once it has been shown long enough
  assign accept_start = start_edge &
                        ((st == S_IDLE) | (((st == S_WIN) | (st == S_OVER)) & end_done));
  assign score_inc    = (st == S_PLAY) & bus.collision_trig;

  bcd_score4 u_score (
    .clk_22 (clk_22),
    .rst    (rst),
    .clr    (accept_start),
    .inc    (score_inc),
    .amount (4'(BRICK_POINTS)),
    .score  (bus.score)
  );

  // Game-tick FSM: every output is registered so a decision shows up one tick later
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      key_q      <= 1'b0;
      serve_cnt  <= '0;
      end_cnt    <= '0;
      lives      <= 2'(LIVES_INIT);
      run        <= 1'b0;
      serve_load <= 1'b0;
      game_start <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      key_q      <= bus.key_start;
      serve_load <= 1'b0;
      game_start <= 1'b0;
      case (st)
        S_IDLE: begin
          run <= 1'b0;
          if (accept_start) begin
            lives      <= 2'(LIVES_INIT);
            game_start <= 1'b1;
            serve_load <= 1'b1;
            serve_cnt  <= '0;
            st         <= S_SERVE;
          end
        end
        S_SERVE: begin
          run <= 1'b0;
          if (serve_cnt == SW'(SERVE_DELAY - 1)) begin
            run <= 1'b1;
            st  <= S_PLAY;
          end else begin
            serve_cnt <= serve_cnt + SW'(1);
          end
        end
        S_PLAY: begin
          run <= 1'b1;
          // An empty field beats a simultaneous miss, so the last life is never lost on a win
          if (bus.bricks_empty) begin
            run     <= 1'b0;
            win     <= 1'b1;
            end_cnt <= '0;
            st      <= S_WIN;
          end else if (miss) begin
            run <= 1'b0;
            if (lives > 2'd1) begin
              lives      <= lives - 2'd1;
              serve_load <= 1'b1;
              serve_cnt  <= '0;
              st         <= S_MISS;
            end else begin
              lives     <= 2'd0;
              game_over <= 1'b1;
              end_cnt   <= '0;
              st        <= S_OVER;
            end
          end
        end
        S_MISS: begin
          run       <= 1'b0;
          serve_cnt <= '0;
          st        <= S_SERVE;
        end
        S_WIN, S_OVER: begin
          run <= 1'b0;
          if (accept_start) begin
            win        <= 1'b0;
            game_over  <= 1'b0;
            lives      <= 2'(LIVES_INIT);
            game_start <= 1'b1;
            serve_load <= 1'b1;
            serve_cnt  <= '0;
            st         <= S_SERVE;
          end else if (!end_done) begin
            end_cnt <= end_cnt + EW'(1);
          end
        end
        default: begin
          run <= 1'b0;
          st  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.state      = st;
  assign bus.run        = run;
  assign bus.serve_load = serve_load;
  assign bus.game_start = game_start;
  assign bus.lives      = lives;
  assign bus.game_over  = game_over;
  assign bus.win        = win;

endmodule
